// File: rtl/fft_stream_writeback.sv
// FFT source stream to grid-memory writeback for one dimension pass.
// Checks SOP/EOP framing, undoes bit-reversed output order, applies the
// 1/N inverse-transform scale and issues one write per accepted sample.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; outputs quiet
// WAIT_SOP | pass open, waiting for the first sample of the next frame
// IN_FRAME | accepting samples 1..FRAME_LEN-1 of the current frame
// DONE     | last frame closed; pass_done fires on the following cycle
module fft_stream_writeback #(
    parameter int DATA_W     = 32,
    parameter int FRAME_LEN  = 32,
    parameter int LOG2_FRAME = 5,
    parameter int NUM_FRAMES = 32,
    parameter int ADDR_W     = 11,
    parameter int BITREV     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        dim_in,
    input  logic              inverse_in,
    input  logic              src_valid,
    input  logic              src_sop,
    input  logic              src_eop,
    input  logic [DATA_W-1:0] src_real,
    input  logic [DATA_W-1:0] src_imag,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_real,
    output logic [DATA_W-1:0] wr_imag,
    output logic [2:0]        wr_dim,
    output logic              busy,
    output logic              pass_done,
    output logic              err_sop,
    output logic              err_eop
);

    localparam int FC_W = $clog2(NUM_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOP, IN_FRAME, DONE} state_t;

    state_t                  state, state_next;
    logic [FC_W-1:0]         frame_cnt;
    logic [LOG2_FRAME-1:0]   sample_cnt;
    logic [LOG2_FRAME-1:0]   idx, idx_m;
    logic [ADDR_W-1:0]       addr_c;
    logic signed [DATA_W-1:0] real_s, imag_s;
    logic                    inv_q;
    logic                    start_ok, accept, frame_close;
    logic                    set_err_sop, set_err_eop;

    function automatic logic [LOG2_FRAME-1:0] bit_rev(input logic [LOG2_FRAME-1:0] v);
        logic [LOG2_FRAME-1:0] r;
        for (int i = 0; i < LOG2_FRAME; i++) begin
            r[i] = v[LOG2_FRAME-1-i];
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, sample acceptance and framing checks
    always_comb begin
        state_next  = state;
        start_ok    = 1'b0;
        accept      = 1'b0;
        frame_close = 1'b0;
        set_err_sop = 1'b0;
        set_err_eop = 1'b0;
        idx         = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (src_valid) begin
                    if (src_sop) begin
                        accept      = 1'b1;
                        set_err_eop = src_eop;
                        state_next  = IN_FRAME;
                    end else begin
                        set_err_sop = 1'b1;
                    end
                end
            end
            IN_FRAME: begin
                if (src_valid) begin
                    accept = 1'b1;
                    // A SOP mid-frame restarts the frame with this sample as index 0
                    if (src_sop) set_err_sop = 1'b1;
                    else         idx = sample_cnt;
                    if (idx == LOG2_FRAME'(FRAME_LEN - 1)) begin
                        frame_close = 1'b1;
                        set_err_eop = !src_eop;
                        state_next  = (frame_cnt == FC_W'(NUM_FRAMES - 1)) ? DONE : WAIT_SOP;
                    end else begin
                        set_err_eop = src_eop;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write address and scaled data for the current sample
    always_comb begin
        idx_m  = (BITREV != 0) ? bit_rev(idx) : idx;
        addr_c = (ADDR_W'(frame_cnt) << LOG2_FRAME) | ADDR_W'(idx_m);
        real_s = $signed(src_real) >>> LOG2_FRAME;
        imag_s = $signed(src_imag) >>> LOG2_FRAME;
    end

    // Pass context, counters, sticky errors and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_dim     <= '0;
            inv_q      <= 1'b0;
            frame_cnt  <= '0;
            sample_cnt <= '0;
            err_sop    <= 1'b0;
            err_eop    <= 1'b0;
            busy       <= 1'b0;
            pass_done  <= 1'b0;
        end else begin
            pass_done <= (state == DONE);
            if (state == DONE) busy <= 1'b0;
            if (start_ok) begin
                wr_dim     <= dim_in;
                inv_q      <= inverse_in;
                frame_cnt  <= '0;
                sample_cnt <= '0;
                err_sop    <= 1'b0;
                err_eop    <= 1'b0;
                busy       <= 1'b1;
            end else begin
                // Index wraps to 0 naturally when the frame closes
                if (accept)      sample_cnt <= idx + LOG2_FRAME'(1);
                if (frame_close) frame_cnt  <= frame_cnt + FC_W'(1);
                if (set_err_sop) err_sop    <= 1'b1;
                if (set_err_eop) err_eop    <= 1'b1;
            end
        end
    end

    // One-cycle write pipeline into the grid memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_real <= '0;
            wr_imag <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= addr_c;
                wr_real <= inv_q ? real_s : src_real;
                wr_imag <= inv_q ? imag_s : src_imag;
            end
        end
    end

endmodule

// File: tb/tb_fft_stream_writeback.sv
// Scoreboard bench: natural-order and bit-reversed instances share one stimulus stream.
module tb_fft_stream_writeback;

    localparam int DW = 32;
    localparam int AW = 11;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    dim_in;
    logic          inverse_in, src_valid, src_sop, src_eop;
    logic [DW-1:0] src_real, src_imag;

    logic          wr_en [2];
    logic [AW-1:0] wr_addr [2];
    logic [DW-1:0] wr_real [2];
    logic [DW-1:0] wr_imag [2];
    logic [2:0]    wr_dim [2];
    logic          busy [2];
    logic          pass_done [2];
    logic          err_sop [2];
    logic          err_eop [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt [2] = '{0, 0};
    logic prev_wr_en [2] = '{1'b0, 1'b0};

    // reference model: 0 idle, 1 wait sop, 2 in frame, 3 done
    int       m_state, m_frame, m_sample;
    bit       m_inv, m_err_sop, m_err_eop;
    logic [2:0] m_dim;
    int       seq, mode, pass_id;

    always #5 clk = ~clk;

    fft_stream_writeback #(.BITREV(0)) dut_nat (
        .clk(clk), .rst(rst), .start(start), .dim_in(dim_in), .inverse_in(inverse_in),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_real(wr_real[0]), .wr_imag(wr_imag[0]),
        .wr_dim(wr_dim[0]), .busy(busy[0]), .pass_done(pass_done[0]),
        .err_sop(err_sop[0]), .err_eop(err_eop[0])
    );

    fft_stream_writeback #(.BITREV(1)) dut_rev (
        .clk(clk), .rst(rst), .start(start), .dim_in(dim_in), .inverse_in(inverse_in),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_real(wr_real[1]), .wr_imag(wr_imag[1]),
        .wr_dim(wr_dim[1]), .busy(busy[1]), .pass_done(pass_done[1]),
        .err_sop(err_sop[1]), .err_eop(err_eop[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int rev5(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) if (k[b]) r |= (1 << (4 - b));
        return r;
    endfunction

    // Monitor: pop expected writes whenever a DUT writes
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (wr_en[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write dut%0d: actual addr %0h required no write", d, wr_addr[d]);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("wr_addr dut%0d", d), 64'(wr_addr[d]), 64'(e.addr));
                    chk($sformatf("wr_real dut%0d", d), 64'(wr_real[d]), 64'(e.re));
                    chk($sformatf("wr_imag dut%0d", d), 64'(wr_imag[d]), 64'(e.im));
                end
            end
            if (pass_done[d]) begin
                done_cnt[d]++;
                chk($sformatf("done_after_last_write dut%0d", d), 64'(prev_wr_en[d]), 64'd1);
            end
            prev_wr_en[d] = wr_en[d];
        end
    end

    task automatic push(input int idx, input logic [DW-1:0] re, input logic [DW-1:0] im);
        exp_t e;
        logic signed [DW-1:0] sr, si;
        sr = re;
        si = im;
        sr = sr >>> 5;
        si = si >>> 5;
        e.re   = m_inv ? sr : re;
        e.im   = m_inv ? si : im;
        e.addr = AW'(m_frame * 32 + idx);
        q0.push_back(e);
        e.addr = AW'(m_frame * 32 + rev5(idx));
        q1.push_back(e);
    endtask

    task automatic smp(input bit v, input bit sop, input bit eop,
                       input logic [DW-1:0] re, input logic [DW-1:0] im);
        bit was_done;
        int idx;
        @(negedge clk);
        start = 1'b0; src_valid = v; src_sop = sop; src_eop = eop;
        src_real = re; src_imag = im;
        was_done = (m_state == 3);
        if (v && m_state == 1) begin
            if (sop) begin
                push(0, re, im);
                if (eop) m_err_eop = 1'b1;
                m_sample = 1;
                m_state = 2;
            end else begin
                m_err_sop = 1'b1;
            end
        end else if (v && m_state == 2) begin
            idx = sop ? 0 : m_sample;
            if (sop) m_err_sop = 1'b1;
            push(idx, re, im);
            if (idx == 31) begin
                if (!eop) m_err_eop = 1'b1;
                m_frame++;
                m_sample = 0;
                m_state = (m_frame == 32) ? 3 : 1;
            end else begin
                if (eop) m_err_eop = 1'b1;
                m_sample = idx + 1;
            end
        end
        if (was_done) m_state = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) smp(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk_flags(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s err_sop dut%0d", tag, d), 64'(err_sop[d]), 64'(m_err_sop));
            chk($sformatf("%s err_eop dut%0d", tag, d), 64'(err_eop[d]), 64'(m_err_eop));
        end
    endtask

    task automatic do_start(input logic [2:0] dim, input bit inv);
        @(negedge clk);
        start = 1'b1; dim_in = dim; inverse_in = inv;
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
        if (m_state == 0) begin
            m_state = 1; m_frame = 0; m_sample = 0;
            m_dim = dim; m_inv = inv; m_err_sop = 1'b0; m_err_eop = 1'b0;
        end else if (m_state == 3) begin
            m_state = 0;
        end
        idle(1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("start busy dut%0d", d), 64'(busy[d]), 64'(m_state == 1 || m_state == 2));
            chk($sformatf("start wr_dim dut%0d", d), 64'(wr_dim[d]), 64'(m_dim));
        end
        chk_flags("start");
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s wr_en dut%0d", tag, d), 64'(wr_en[d]), 64'd0);
            chk($sformatf("%s wr_addr dut%0d", tag, d), 64'(wr_addr[d]), 64'd0);
            chk($sformatf("%s wr_real dut%0d", tag, d), 64'(wr_real[d]), 64'd0);
            chk($sformatf("%s wr_imag dut%0d", tag, d), 64'(wr_imag[d]), 64'd0);
            chk($sformatf("%s wr_dim dut%0d", tag, d), 64'(wr_dim[d]), 64'd0);
            chk($sformatf("%s busy dut%0d", tag, d), 64'(busy[d]), 64'd0);
            chk($sformatf("%s pass_done dut%0d", tag, d), 64'(pass_done[d]), 64'd0);
            chk($sformatf("%s err_sop dut%0d", tag, d), 64'(err_sop[d]), 64'd0);
            chk($sformatf("%s err_eop dut%0d", tag, d), 64'(err_eop[d]), 64'd0);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; start = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero(tag);
        q0.delete();
        q1.delete();
        m_state = 0; m_frame = 0; m_sample = 0; m_inv = 1'b0; m_dim = '0;
        m_err_sop = 1'b0; m_err_eop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_end(input string tag, input int dones);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s done_cnt dut%0d", tag, d), 64'(done_cnt[d]), 64'(dones));
            chk($sformatf("%s busy dut%0d", tag, d), 64'(busy[d]), 64'd0);
            chk($sformatf("%s wr_dim dut%0d", tag, d), 64'(wr_dim[d]), 64'(m_dim));
        end
        chk($sformatf("%s pending_nat", tag), 64'(q0.size()), 64'd0);
        chk($sformatf("%s pending_rev", tag), 64'(q1.size()), 64'd0);
        chk_flags(tag);
    endtask

    task automatic gen(input int s, output logic [DW-1:0] re, output logic [DW-1:0] im);
        if (mode == 0) begin
            re = DW'(s);
            im = ~DW'(s);
        end else if (s == 0) begin
            re = 32'hFFFF_FFC0;
            im = 32'd100;
        end else if (s == 1) begin
            re = 32'hFFFF_FFFF;
            im = 32'd7;
        end else begin
            re = DW'(s * 37 - 20000);
            im = DW'(s * 101 - 3000);
        end
    endtask

    // Hand-computed spot checks at specific points of each pass
    task automatic hook(input int f, input int i, input int n, input bit bub);
        int vis;
        vis = bub ? i : i - 1;
        if (pass_id == 1 && f == 0 && vis == 1) begin
            chk("nat f0 s1 addr", 64'(wr_addr[0]), 64'd1);
            chk("rev f0 s1 wr_en", 64'(wr_en[1]), 64'd1);
            chk("rev f0 s1 addr", 64'(wr_addr[1]), 64'd16);
            chk("rev f0 s1 real", 64'(wr_real[1]), 64'd1);
        end
        if (pass_id == 1 && f == 0 && vis == 3) chk("rev f0 s3 addr", 64'(wr_addr[1]), 64'd24);
        if (pass_id == 1 && f == 1 && vis == 1) chk("rev f1 s1 addr", 64'(wr_addr[1]), 64'd48);
        if (pass_id == 2 && f == 0 && vis == 0) begin
            chk("inv real -64", 64'(wr_real[0]), 64'hFFFF_FFFE);
            chk("inv imag 100", 64'(wr_imag[0]), 64'd3);
        end
        if (pass_id == 2 && f == 0 && vis == 1) chk("inv real -1", 64'(wr_real[0]), 64'hFFFF_FFFF);
        if (pass_id == 3 && f == 1 && i == n + 1) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("midsop wr_en dut%0d", d), 64'(wr_en[d]), 64'd1);
                chk($sformatf("midsop addr dut%0d", d), 64'(wr_addr[d]), 64'd32);
                chk($sformatf("midsop err_sop dut%0d", d), 64'(err_sop[d]), 64'd1);
            end
        end
        if (pass_id == 3 && f == 2 && i == 6) begin
            for (int d = 0; d < 2; d++)
                chk($sformatf("early eop err_eop dut%0d", d), 64'(err_eop[d]), 64'd1);
        end
        if (pass_id == 5 && f == 0 && vis == 0) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("restart wr_en dut%0d", d), 64'(wr_en[d]), 64'd1);
                chk($sformatf("restart addr dut%0d", d), 64'(wr_addr[d]), 64'd0);
            end
        end
    endtask

    task automatic send_frame(input int f, input int sop_at, input int early_eop,
                              input bit last_eop, input bit bub);
        logic [DW-1:0] re, im;
        for (int i = 0; i < sop_at + 32; i++) begin
            int k;
            k = (i < sop_at) ? i : i - sop_at;
            gen(seq, re, im);
            seq++;
            smp(1'b1, k == 0, (k == early_eop) || (k == 31 && last_eop), re, im);
            if (bub) smp(1'b0, 1'b0, 1'b0, re, im);
            hook(f, i, sop_at, bub);
        end
    endtask

    initial begin
        logic [DW-1:0] re, im;
        rst = 1'b1; start = 1'b0; dim_in = '0; inverse_in = 1'b0;
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; src_real = '0; src_imag = '0;
        m_state = 0; m_frame = 0; m_sample = 0; m_inv = 1'b0; m_dim = '0;
        m_err_sop = 1'b0; m_err_eop = 1'b0;
        seq = 0; mode = 0; pass_id = 0;
        #3 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // clean forward pass, natural and bit-reversed order
        pass_id = 1; mode = 0; seq = 0;
        do_start(3'b001, 1'b0);
        for (int f = 0; f < 32; f++) send_frame(f, 0, -1, 1'b1, 1'b0);
        idle(4);
        chk_end("fwd", 1);

        // inverse pass with bubbles every other cycle and an ignored start
        pass_id = 2; mode = 1; seq = 0;
        do_start(3'b010, 1'b1);
        for (int f = 0; f < 32; f++) begin
            if (f == 3) do_start(3'b100, 1'b0);
            send_frame(f, 0, -1, 1'b1, 1'b1);
        end
        idle(4);
        chk_end("inv", 2);

        // framing errors: mid-frame sop, early eop
        pass_id = 3;
        do_start(3'b100, 1'b0);
        for (int f = 0; f < 32; f++)
            send_frame(f, (f == 1) ? 10 : 0, (f == 2) ? 5 : -1, 1'b1, 1'b0);
        idle(4);
        chk_end("err", 3);

        // new start clears errors; valid without sop; reset mid frame 7
        pass_id = 4;
        do_start(3'b010, 1'b0);
        smp(1'b1, 1'b0, 1'b0, 32'h1234, 32'h5678);
        idle(1);
        chk_flags("nosop");
        chk("nosop wr_en nat", 64'(wr_en[0]), 64'd0);
        chk("nosop wr_en rev", 64'(wr_en[1]), 64'd0);
        for (int f = 0; f < 7; f++) send_frame(f, 0, -1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            gen(seq, re, im);
            seq++;
            smp(1'b1, k == 0, 1'b0, re, im);
        end
        apply_reset("midreset");

        // fresh pass after reset, frame 0 missing its eop
        pass_id = 5;
        do_start(3'b001, 1'b0);
        send_frame(0, 0, -1, 1'b0, 1'b0);
        idle(1);
        chk_flags("noeop");
        for (int f = 1; f < 32; f++) send_frame(f, 0, -1, 1'b1, 1'b0);
        idle(4);
        chk_end("postreset", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
